// File: rtl/fifo_arbiter.sv
// fifo_arbiter: two-producer round-robin push arbiter and pop gate placed in
// front of a DEPTH-entry FIFO. It tracks committed occupancy, so the FIFO is
// never pushed while full or popped while empty. It also raises a sticky error
// if the FIFO flags ever disagree with that bookkeeping.
//
// Ports
//   clk_i                  rising-edge clock
//   rst_i                  synchronous reset, active low
//   req0_i / data0_i       producer 0 request (held until granted) and payload
//   req1_i / data1_i       producer 1 request and payload
//   gnt0_o / gnt1_o        combinational grants; payload captured on this edge
//   fifo_data_in_o         registered payload to FIFO data_in
//   fifo_data_in_valid_o   registered push strobe to FIFO data_in_valid
//   fifo_full_i/_empty_i   FIFO status flags
//   pop_req_i              consumer pop request
//   pop_fifo_o             combinational pop strobe to FIFO
//   count_o                committed occupancy, including an in-flight push
//   err_o                  sticky protocol error
module fifo_arbiter #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic             req1_i,
  input  logic [WIDTH-1:0] data1_i,
  output logic             gnt0_o,
  output logic             gnt1_o,
  output logic [WIDTH-1:0] fifo_data_in_o,
  output logic             fifo_data_in_valid_o,
  input  logic             fifo_full_i,
  input  logic             fifo_empty_i,
  input  logic             pop_req_i,
  output logic             pop_fifo_o,
  output logic [CW-1:0]    count_o,
  output logic             err_o
);

  logic             rr_last_q, rr_last_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic [CW-1:0]    stored;
  logic             pop, can_push, g0, g1;

  // A granted push is held in out_data_q for one cycle before the FIFO stores
  // it, so the entries actually resident are count minus that in-flight push.
  // A pop in the same cycle frees a slot early enough to allow a grant at full.
  always_comb begin
    stored   = count_q - CW'(out_valid_q);
    pop      = rst_i & pop_req_i & (stored != '0);
    can_push = (count_q < CW'(DEPTH)) | pop;
    // On a tie, grant the producer that did not win last time.
    g0 = rst_i & can_push & req0_i & (~req1_i | rr_last_q);
    g1 = rst_i & can_push & req1_i & (~req0_i | ~rr_last_q);
  end

  always_comb begin
    rr_last_d   = rr_last_q;
    out_data_d  = out_data_q;
    out_valid_d = g0 | g1;
    if (g0) begin
      out_data_d = data0_i;
      rr_last_d  = 1'b0;
    end else if (g1) begin
      out_data_d = data1_i;
      rr_last_d  = 1'b1;
    end
    count_d = count_q + CW'(g0 | g1) - CW'(pop);
    err_d   = err_q
            | (out_valid_q & fifo_full_i & ~pop)
            | (pop & fifo_empty_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      rr_last_q   <= 1'b1;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      rr_last_q   <= rr_last_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end

  assign gnt0_o               = g0;
  assign gnt1_o               = g1;
  assign pop_fifo_o           = pop;
  assign fifo_data_in_o       = out_data_q;
  assign fifo_data_in_valid_o = out_valid_q;
  assign count_o              = count_q;
  assign err_o                = err_q;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter. It includes a small behavioural model of the 4-entry
// FIFO. Directed stimulus queues the payload it expects to come out of the
// FIFO, and a monitor pops and compares it whenever pop_fifo removes an entry.
module tb_fifo_arbiter;
  localparam int WIDTH = 64;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, pop_req;
  logic [WIDTH-1:0] data0, data1;
  logic             gnt0, gnt1, pop_fifo, fdv, err;
  logic [WIDTH-1:0] fdata;
  logic [CW-1:0]    count;
  logic             m_full = 1'b0, m_empty = 1'b1;
  logic             inj_full, inj_empty;
  logic             fifo_full, fifo_empty;

  int checks = 0;
  int fails  = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fq[$];
  logic [WIDTH-1:0] got, want;

  assign fifo_full  = m_full  | inj_full;
  assign fifo_empty = m_empty | inj_empty;

  always #5 clk = ~clk;

  fifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .data0_i(data0), .req1_i(req1), .data1_i(data1),
    .gnt0_o(gnt0), .gnt1_o(gnt1),
    .fifo_data_in_o(fdata), .fifo_data_in_valid_o(fdv),
    .fifo_full_i(fifo_full), .fifo_empty_i(fifo_empty),
    .pop_req_i(pop_req), .pop_fifo_o(pop_fifo),
    .count_o(count), .err_o(err)
  );

  // FIFO model plus scoreboard monitor. The flags are updated with NBAs so the
  // DUT samples the pre-edge values.
  always @(posedge clk) begin
    if (!rst) begin
      fq.delete();
      m_full  <= 1'b0;
      m_empty <= 1'b1;
    end else begin
      if (pop_fifo) begin
        checks++;
        if (fq.size() == 0) begin
          fails++;
          $display("FAIL fifo_underflow actual=pop required=no_pop");
        end else begin
          got = fq.pop_front();
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL pop_data actual=%0h required=none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              fails++;
              $display("FAIL pop_data actual=%0h required=%0h", got, want);
            end
          end
        end
      end
      if (fdv) begin
        if (fq.size() >= DEPTH) begin
          checks++;
          fails++;
          $display("FAIL fifo_overflow actual=push required=no_push");
        end else fq.push_back(fdata);
      end
      m_full  <= (fq.size() == DEPTH);
      m_empty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n0, n1;
    rst = 1'b0; req0 = 0; req1 = 0; pop_req = 0; data0 = '0; data1 = '0;
    inj_full = 0; inj_empty = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // reset state
    chk("rst_count", 64'(count), 0);
    chk("rst_valid", 64'(fdv), 0);
    chk("rst_gnt0", 64'(gnt0), 0);
    chk("rst_gnt1", 64'(gnt1), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_empty", 64'(fifo_empty), 1);
    req0 = 1; req1 = 1; pop_req = 1;
    #1;
    chk("gnt0_in_rst", 64'(gnt0), 0);
    chk("gnt1_in_rst", 64'(gnt1), 0);
    chk("pop_in_rst", 64'(pop_fifo), 0);
    req1 = 0; pop_req = 0; rst = 1;

    // single producer fill
    for (int i = 0; i < 4; i++) begin
      data0 = 64'h11 * 64'(i + 1);
      #1;
      chk("fill_gnt0", 64'(gnt0), 1);
      chk("fill_count", 64'(count), 64'(i));
      exp_q.push_back(data0);
      step();
    end
    data0 = 64'h55;
    #1;
    chk("full_gnt0", 64'(gnt0), 0);
    chk("full_count", 64'(count), 4);
    chk("full_inflight", 64'(fdv), 1);
    chk("full_flag_early", 64'(fifo_full), 0);
    step();
    chk("full_flag", 64'(fifo_full), 1);
    chk("full_gnt0_b", 64'(gnt0), 0);
    chk("full_err", 64'(err), 0);
    req0 = 0;

    // full with simultaneous pop and push
    req1 = 1; data1 = 64'hAA; pop_req = 1;
    #1;
    chk("fp_pop", 64'(pop_fifo), 1);
    chk("fp_gnt1", 64'(gnt1), 1);
    chk("fp_gnt0", 64'(gnt0), 0);
    exp_q.push_back(64'hAA);
    step();
    req1 = 0; pop_req = 0;
    chk("fp_count", 64'(count), 4);
    chk("fp_full_gap", 64'(fifo_full), 0);
    step();
    chk("fp_full", 64'(fifo_full), 1);
    chk("fp_err", 64'(err), 0);

    // drain
    pop_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_pop", 64'(pop_fifo), 1);
      chk("drain_count", 64'(count), 64'(4 - i));
      step();
    end
    #1;
    chk("drain_count0", 64'(count), 0);
    chk("drain_nopop", 64'(pop_fifo), 0);
    chk("drain_empty", 64'(fifo_empty), 1);
    pop_req = 0;

    // round-robin tie from reset
    rst = 0;
    step();
    rst = 1; req0 = 1; req1 = 1; pop_req = 1; n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      data0 = 64'hA0 + 64'(n0);
      data1 = 64'hB0 + 64'(n1);
      #1;
      chk("rr_gnt0", 64'(gnt0), 64'(k % 2 == 0));
      chk("rr_gnt1", 64'(gnt1), 64'(k % 2 == 1));
      chk("rr_pop", 64'(pop_fifo), 64'(k >= 2));
      if (k % 2 == 0) begin exp_q.push_back(data0); n0++; end
      else begin exp_q.push_back(data1); n1++; end
      step();
    end
    req0 = 0; req1 = 0;
    #1;
    chk("rr_count", 64'(count), 2);
    step(); step();
    chk("rr_drained", 64'(count), 0);
    chk("rr_empty", 64'(fifo_empty), 1);
    pop_req = 0;

    // empty boundary with an in-flight push
    req0 = 1; data0 = 64'h5A; pop_req = 1;
    #1;
    chk("if_gnt0", 64'(gnt0), 1);
    chk("if_pop0", 64'(pop_fifo), 0);
    exp_q.push_back(64'h5A);
    step();
    req0 = 0;
    #1;
    chk("if_pop1", 64'(pop_fifo), 0);
    chk("if_count1", 64'(count), 1);
    step();
    chk("if_pop2", 64'(pop_fifo), 1);
    step();
    pop_req = 0;
    chk("if_count0", 64'(count), 0);
    chk("if_err", 64'(err), 0);

    // reset mid-stream discards the in-flight push and restores priority
    req0 = 1; data0 = 64'h77;
    #1;
    chk("ms_gnt0", 64'(gnt0), 1);
    step();
    rst = 0; req1 = 1;
    #1;
    chk("ms_gnt0_rst", 64'(gnt0), 0);
    chk("ms_gnt1_rst", 64'(gnt1), 0);
    step();
    chk("ms_valid", 64'(fdv), 0);
    chk("ms_count", 64'(count), 0);
    chk("ms_empty", 64'(fifo_empty), 1);
    rst = 1; data0 = 64'h78;
    #1;
    chk("ms_tie_gnt0", 64'(gnt0), 1);
    chk("ms_tie_gnt1", 64'(gnt1), 0);
    exp_q.push_back(64'h78);
    step();
    req0 = 0; req1 = 0; pop_req = 1;
    step(); step();
    chk("ms_count0", 64'(count), 0);
    pop_req = 0;

    // error: pop while the FIFO reports empty
    req0 = 1; data0 = 64'h99;
    step();
    req0 = 0;
    step();
    pop_req = 1; inj_empty = 1;
    #1;
    chk("e1_pop", 64'(pop_fifo), 1);
    chk("e1_err_pre", 64'(err), 0);
    exp_q.push_back(64'h99);
    step();
    pop_req = 0; inj_empty = 0;
    chk("e1_err", 64'(err), 1);
    step();
    chk("e1_sticky", 64'(err), 1);
    rst = 0;
    step();
    rst = 1;
    chk("e1_cleared", 64'(err), 0);

    // error: push strobe while the FIFO reports full
    req0 = 1; data0 = 64'h66;
    step();
    req0 = 0; inj_full = 1;
    #1;
    chk("e2_err_pre", 64'(err), 0);
    step();
    inj_full = 0;
    chk("e2_err", 64'(err), 1);
    rst = 0;
    step();
    rst = 1;
    chk("e2_cleared", 64'(err), 0);

    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
